// File: rtl/clock_seq_ctrl.sv
// clock_seq_ctrl: 1 Hz prescaler, seconds/minutes/hours strobes and set-mode FSM for the lab clock.
// Define CLOCK_SEQ_PAUSE_EN to add the PAUSE mode (adj toggles RUN <-> PAUSE).
module clock_seq_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_DIV   = 25000000,
    parameter int REPEAT_DIV = 12500000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       btn_mode_i,
    input  logic       btn_adj_i,
    input  logic       btn_clr_i,
    input  logic       sec_carry_i,
    input  logic       min_carry_i,
    output logic       inc_sec_o,
    output logic       inc_min_o,
    output logic       inc_hr_o,
    output logic       clr_sec_o,
    output logic       clr_all_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);
    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_MIN = 2'b01;
    localparam logic [1:0] SET_HR  = 2'b10;
    localparam logic [1:0] PAUSE   = 2'b11;
`ifdef CLOCK_SEQ_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif
    localparam int CW   = $clog2(TICK_DIV + 1);
    localparam int RMAX = (HOLD_DIV > REPEAT_DIV) ? HOLD_DIV : REPEAT_DIV;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(TICK_DIV / 2 - 1);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_DIV - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_DIV - 1);

    // Button vectors are ordered {clr, mode, adj}
    logic [2:0]    s1_q, s2_q, prev_q, edg;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_on_q, rep_on_d, blink_q, blink_d;
    logic          inc_sec_q, inc_sec_d, inc_min_q, inc_min_d, inc_hr_q, inc_hr_d;
    logic          clr_sec_q, clr_sec_d, clr_all_q, clr_all_d;
    logic          clr_e, mode_e, adj_e, adj_hi, set_mode, rep_fire, tick;

    assign edg      = s2_q & ~prev_q;
    assign clr_e    = edg[2];
    assign mode_e   = edg[1];
    assign adj_e    = edg[0];
    assign adj_hi   = s2_q[0];
    assign set_mode = (mode_q == SET_MIN) || (mode_q == SET_HR);
    assign tick     = cnt_q == TICK_LAST;
    // First repeat after HOLD_DIV cycles of holding, then every REPEAT_DIV cycles
    assign rep_fire = set_mode && adj_hi && !adj_e && (rep_q == (rep_on_q ? REP_LAST : HOLD_LAST));

    always_comb begin
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        rep_d     = '0;
        rep_on_d  = 1'b0;
        blink_d   = blink_q;
        inc_sec_d = 1'b0;
        inc_min_d = 1'b0;
        inc_hr_d  = 1'b0;
        clr_sec_d = 1'b0;
        clr_all_d = 1'b0;
        if (clr_e) begin
            clr_all_d = 1'b1;
            mode_d    = RUN;
            cnt_d     = '0;
            blink_d   = 1'b0;
        end else if (mode_e) begin
            mode_d    = (mode_q == SET_MIN) ? SET_HR : (mode_q == SET_HR) ? RUN : SET_MIN;
            cnt_d     = '0;
            blink_d   = mode_q != SET_HR;
            clr_sec_d = mode_q == SET_HR;
        end else if (set_mode) begin
            // In set modes the prescaler becomes the blink half-period counter
            rep_d     = (adj_e || !adj_hi || rep_fire) ? '0 : rep_q + 1'b1;
            rep_on_d  = adj_hi && !adj_e && (rep_on_q || rep_fire);
            inc_min_d = (adj_e || rep_fire) && mode_q == SET_MIN;
            inc_hr_d  = (adj_e || rep_fire) && mode_q == SET_HR;
            cnt_d     = (cnt_q == HALF_LAST) ? '0 : cnt_q + 1'b1;
            blink_d   = blink_q ^ (cnt_q == HALF_LAST);
        end else if (PAUSE_EN && mode_q == PAUSE) begin
            mode_d  = adj_e ? RUN : PAUSE;
            blink_d = !adj_e;
        end else if (PAUSE_EN && adj_e) begin
            mode_d  = PAUSE;
            blink_d = 1'b1;
        end else begin
            cnt_d     = tick ? '0 : cnt_q + 1'b1;
            inc_sec_d = tick;
            inc_min_d = tick && sec_carry_i;
            inc_hr_d  = tick && sec_carry_i && min_carry_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            mode_q    <= RUN;
            cnt_q     <= '0;
            rep_q     <= '0;
            rep_on_q  <= 1'b0;
            blink_q   <= 1'b0;
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
            inc_hr_q  <= 1'b0;
            clr_sec_q <= 1'b0;
            clr_all_q <= 1'b0;
        end else begin
            s1_q      <= {btn_clr_i, btn_mode_i, btn_adj_i};
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            rep_on_q  <= rep_on_d;
            blink_q   <= blink_d;
            inc_sec_q <= inc_sec_d;
            inc_min_q <= inc_min_d;
            inc_hr_q  <= inc_hr_d;
            clr_sec_q <= clr_sec_d;
            clr_all_q <= clr_all_d;
        end
    end

    assign inc_sec_o = inc_sec_q;
    assign inc_min_o = inc_min_q;
    assign inc_hr_o  = inc_hr_q;
    assign clr_sec_o = clr_sec_q;
    assign clr_all_o = clr_all_q;
    assign mode_o    = mode_q;
    assign blink_o   = blink_q;
endmodule
